// File: rtl/ex_pipe_ctrl.sv
// Pipeline sequencing controller around the execute stage: stage enables, bubbles,
// flushes, PC select, shadow per-stage control state and stall/flush counters.
module ex_pipe_ctrl #(
    parameter int unsigned RW  = 5,
    parameter int unsigned CW  = 32,
    parameter int unsigned FWD = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RW-1:0] id_rs1,
    input  logic [RW-1:0] id_rs2,
    input  logic          id_use_rs1,
    input  logic          id_use_rs2,
    input  logic [RW-1:0] id_rd,
    input  logic          id_reg_write,
    input  logic          id_is_load,
    input  logic          id_is_branch,
    input  logic          id_br_inv,
    input  logic          zero,
    input  logic          dmem_ready,
    output logic          pc_en,
    output logic          pc_sel,
    output logic          ifid_en,
    output logic          idex_en,
    output logic          exmem_en,
    output logic          memwb_en,
    output logic          idex_bubble,
    output logic          ifid_flush,
    output logic          exmem_flush,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ACT_RUN,
        ACT_STALL,
        ACT_FLUSH,
        ACT_FREEZE
    } act_t;

    act_t act;

    logic          v_id, v_ex, v_mem;
    logic [RW-1:0] ex_rd, mem_rd;
    logic          ex_reg_write, mem_reg_write;
    logic          ex_is_load, mem_is_load;
    logic          ex_is_branch, mem_is_branch;
    logic          ex_br_inv, mem_br_inv;

    logic mem_stall, br_taken;
    logic wr_ex, wr_mem, match_ex, match_mem;
    logic haz_fwd, haz_nofwd, hazard;
    logic mem_load_unused;

    // mem_is_load is part of the observable shadow state but no decision reads it
    assign mem_load_unused = mem_is_load;

    always_comb begin
        mem_stall = ~dmem_ready;
        br_taken  = v_mem & mem_is_branch & (zero ^ mem_br_inv);
        wr_ex     = v_ex & ex_reg_write & (ex_rd != '0);
        wr_mem    = v_mem & mem_reg_write & (mem_rd != '0);
        match_ex  = (id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd));
        match_mem = (id_use_rs1 & (id_rs1 == mem_rd)) | (id_use_rs2 & (id_rs2 == mem_rd));
        haz_fwd   = v_id & wr_ex & ex_is_load & match_ex;
        haz_nofwd = v_id & ((wr_ex & match_ex) | (wr_mem & match_mem));
        hazard    = (FWD != 0) ? haz_fwd : haz_nofwd;
    end

    // Reset is folded into FREEZE so every control output drops to 0 while rst is high
    always_comb begin
        act = ACT_RUN;
        if (rst || mem_stall) begin
            act = ACT_FREEZE;
        end else if (br_taken) begin
            act = ACT_FLUSH;
        end else if (hazard) begin
            act = ACT_STALL;
        end
    end

    always_comb begin
        pc_en       = 1'b0;
        pc_sel      = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        exmem_flush = 1'b0;
        case (act)
            ACT_RUN: begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
            ACT_FLUSH: begin
                pc_en       = 1'b1;
                pc_sel      = 1'b1;
                ifid_en     = 1'b1;
                idex_en     = 1'b1;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
                idex_bubble = 1'b1;
                ifid_flush  = 1'b1;
                exmem_flush = 1'b1;
            end
            ACT_STALL: begin
                idex_en     = 1'b1;
                idex_bubble = 1'b1;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_id          <= 1'b0;
            v_ex          <= 1'b0;
            v_mem         <= 1'b0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_is_load    <= 1'b0;
            ex_is_branch  <= 1'b0;
            ex_br_inv     <= 1'b0;
            mem_rd        <= '0;
            mem_reg_write <= 1'b0;
            mem_is_load   <= 1'b0;
            mem_is_branch <= 1'b0;
            mem_br_inv    <= 1'b0;
            stall_cnt     <= '0;
            flush_cnt     <= '0;
        end else begin
            case (act)
                ACT_RUN: begin
                    v_id          <= 1'b1;
                    v_ex          <= v_id;
                    ex_rd         <= id_rd;
                    ex_reg_write  <= id_reg_write;
                    ex_is_load    <= id_is_load;
                    ex_is_branch  <= id_is_branch;
                    ex_br_inv     <= id_br_inv;
                    v_mem         <= v_ex;
                    mem_rd        <= ex_rd;
                    mem_reg_write <= ex_reg_write;
                    mem_is_load   <= ex_is_load;
                    mem_is_branch <= ex_is_branch;
                    mem_br_inv    <= ex_br_inv;
                end
                ACT_STALL: begin
                    v_ex          <= 1'b0;
                    ex_rd         <= '0;
                    ex_reg_write  <= 1'b0;
                    ex_is_load    <= 1'b0;
                    ex_is_branch  <= 1'b0;
                    ex_br_inv     <= 1'b0;
                    v_mem         <= v_ex;
                    mem_rd        <= ex_rd;
                    mem_reg_write <= ex_reg_write;
                    mem_is_load   <= ex_is_load;
                    mem_is_branch <= ex_is_branch;
                    mem_br_inv    <= ex_br_inv;
                    stall_cnt     <= stall_cnt + 1'b1;
                end
                ACT_FLUSH: begin
                    v_id          <= 1'b1;
                    v_ex          <= 1'b0;
                    v_mem         <= 1'b0;
                    ex_rd         <= '0;
                    ex_reg_write  <= 1'b0;
                    ex_is_load    <= 1'b0;
                    ex_is_branch  <= 1'b0;
                    ex_br_inv     <= 1'b0;
                    mem_rd        <= '0;
                    mem_reg_write <= 1'b0;
                    mem_is_load   <= 1'b0;
                    mem_is_branch <= 1'b0;
                    mem_br_inv    <= 1'b0;
                    flush_cnt     <= flush_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_pipe_ctrl.sv
// Bench for ex_pipe_ctrl: forwarding instance driven from a vector table,
// no-forwarding instance (2-bit counters) driven by a hand-written sequence.
module tb_ex_pipe_ctrl;

    localparam logic [8:0] NORM   = 9'b101111000;
    localparam logic [8:0] STALL  = 9'b000111100;
    localparam logic [8:0] FLUSH  = 9'b111111111;
    localparam logic [8:0] FREEZE = 9'b000000000;

    typedef struct {
        int       tag;
        int       sel;
        int       rst, rdy, zero;
        int       rs1, u1, rs2, u2;
        int       rd, rw, ld, br, inv;
        logic [8:0] ctl;
        int unsigned sc, fc;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, zero, dmem_ready;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2, id_reg_write, id_is_load, id_is_branch, id_br_inv;

    logic        pc_en1, pc_sel1, ifid_en1, idex_en1, exmem_en1, memwb_en1;
    logic        bub1, ifl1, exfl1;
    logic [31:0] sc1, fc1;
    logic        pc_en0, pc_sel0, ifid_en0, idex_en0, exmem_en0, memwb_en0;
    logic        bub0, ifl0, exfl0;
    logic [1:0]  sc0, fc0;

    ex_pipe_ctrl #(.RW(5), .CW(32), .FWD(1)) u_f1 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_is_branch(id_is_branch),
        .id_br_inv(id_br_inv), .zero(zero), .dmem_ready(dmem_ready),
        .pc_en(pc_en1), .pc_sel(pc_sel1), .ifid_en(ifid_en1), .idex_en(idex_en1),
        .exmem_en(exmem_en1), .memwb_en(memwb_en1), .idex_bubble(bub1),
        .ifid_flush(ifl1), .exmem_flush(exfl1), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    ex_pipe_ctrl #(.RW(5), .CW(2), .FWD(0)) u_f0 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_is_branch(id_is_branch),
        .id_br_inv(id_br_inv), .zero(zero), .dmem_ready(dmem_ready),
        .pc_en(pc_en0), .pc_sel(pc_sel0), .ifid_en(ifid_en0), .idex_en(idex_en0),
        .exmem_en(exmem_en0), .memwb_en(memwb_en0), .idex_bubble(bub0),
        .ifid_flush(ifl0), .exmem_flush(exfl0), .stall_cnt(sc0), .flush_cnt(fc0)
    );

    vec_t        sbq[$];
    vec_t        tbl[33];
    int unsigned napplied = 0;
    int unsigned nmis = 0;
    int          ntag = 0;

    function automatic vec_t mk(int sel, int rst_, int rdy, int z,
                                int rs1, int u1, int rs2, int u2,
                                int rd, int rw, int ld, int br, int inv,
                                logic [8:0] ctl, int unsigned sc, int unsigned fc);
        vec_t v;
        v.tag = 0; v.sel = sel; v.rst = rst_; v.rdy = rdy; v.zero = z;
        v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.rd = rd; v.rw = rw; v.ld = ld; v.br = br; v.inv = inv;
        v.ctl = ctl; v.sc = sc; v.fc = fc;
        return v;
    endfunction

    task automatic check();
        vec_t        e;
        logic [8:0]  act;
        logic [31:0] asc, afc;
        e = sbq.pop_front();
        if (e.sel != 0) begin
            act = {pc_en1, pc_sel1, ifid_en1, idex_en1, exmem_en1, memwb_en1, bub1, ifl1, exfl1};
            asc = sc1;
            afc = fc1;
        end else begin
            act = {pc_en0, pc_sel0, ifid_en0, idex_en0, exmem_en0, memwb_en0, bub0, ifl0, exfl0};
            asc = {30'b0, sc0};
            afc = {30'b0, fc0};
        end
        napplied++;
        if (act !== e.ctl || asc !== e.sc || afc !== e.fc) begin
            nmis++;
            $display("FAIL vec%0d fwd%0d: ctl=%b stall=%0d flush=%0d, expected ctl=%b stall=%0d flush=%0d",
                     e.tag, e.sel, act, asc, afc, e.ctl, e.sc, e.fc);
        end
    endtask

    task automatic drive(input vec_t v);
        @(posedge clk);
        #1;
        v.tag        = ntag++;
        rst          = v.rst[0];
        dmem_ready   = v.rdy[0];
        zero         = v.zero[0];
        id_rs1       = 5'(v.rs1);
        id_use_rs1   = v.u1[0];
        id_rs2       = 5'(v.rs2);
        id_use_rs2   = v.u2[0];
        id_rd        = 5'(v.rd);
        id_reg_write = v.rw[0];
        id_is_load   = v.ld[0];
        id_is_branch = v.br[0];
        id_br_inv    = v.inv[0];
        sbq.push_back(v);
        @(negedge clk);
        check();
    endtask

    initial begin
        rst = 1'b1; dmem_ready = 1'b1; zero = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_reg_write = 1'b0;
        id_is_load = 1'b0; id_is_branch = 1'b0; id_br_inv = 1'b0;

        //            sel rst rdy z  rs1 u1 rs2 u2 rd rw ld br inv  ctl     sc fc
        tbl[0]  = mk(1, 1, 1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  FREEZE, 0, 0);
        tbl[1]  = mk(1, 1, 1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  FREEZE, 0, 0);
        tbl[2]  = mk(1, 0, 1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  NORM,   0, 0);
        tbl[3]  = mk(1, 0, 1, 0,  2, 1,  0, 0,  5, 1, 1, 0, 0,  NORM,   0, 0);
        tbl[4]  = mk(1, 0, 1, 0,  5, 1,  7, 1,  6, 1, 0, 0, 0,  STALL,  0, 0);
        tbl[5]  = mk(1, 0, 1, 0,  5, 1,  7, 1,  6, 1, 0, 0, 0,  NORM,   1, 0);
        tbl[6]  = mk(1, 0, 1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  NORM,   1, 0);
        tbl[7]  = mk(1, 0, 1, 0,  1, 1,  2, 1,  0, 0, 0, 1, 0,  NORM,   1, 0);
        tbl[8]  = mk(1, 0, 1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  NORM,   1, 0);
        tbl[9]  = mk(1, 0, 1, 1,  0, 0,  0, 0,  0, 0, 0, 0, 0,  FLUSH,  1, 0);
        tbl[10] = mk(1, 0, 1, 1,  0, 0,  0, 0,  0, 0, 0, 0, 0,  NORM,   1, 1);
        tbl[11] = mk(1, 0, 1, 0,  1, 1,  2, 1,  0, 0, 0, 1, 0,  NORM,   1, 1);
        tbl[12] = mk(1, 0, 1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  NORM,   1, 1);
        tbl[13] = mk(1, 0, 1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  NORM,   1, 1);
        tbl[14] = mk(1, 0, 1, 0,  1, 1,  2, 1,  0, 0, 0, 1, 1,  NORM,   1, 1);
        tbl[15] = mk(1, 0, 1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  NORM,   1, 1);
        tbl[16] = mk(1, 0, 1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  FLUSH,  1, 1);
        tbl[17] = mk(1, 0, 1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  NORM,   1, 2);
        tbl[18] = mk(1, 0, 1, 0,  1, 1,  2, 1,  0, 0, 0, 1, 0,  NORM,   1, 2);
        tbl[19] = mk(1, 0, 1, 0,  0, 0,  0, 0,  8, 1, 1, 0, 0,  NORM,   1, 2);
        tbl[20] = mk(1, 0, 1, 1,  8, 1,  0, 0,  9, 1, 0, 0, 0,  FLUSH,  1, 2);
        tbl[21] = mk(1, 0, 1, 0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  NORM,   1, 3);
        tbl[22] = mk(1, 0, 1, 0,  0, 0,  0, 0,  9, 1, 1, 0, 0,  NORM,   1, 3);
        tbl[23] = mk(1, 0, 0, 0,  0, 0,  9, 1, 10, 1, 0, 0, 0,  FREEZE, 1, 3);
        tbl[24] = mk(1, 0, 0, 0,  0, 0,  9, 1, 10, 1, 0, 0, 0,  FREEZE, 1, 3);
        tbl[25] = mk(1, 0, 0, 0,  0, 0,  9, 1, 10, 1, 0, 0, 0,  FREEZE, 1, 3);
        tbl[26] = mk(1, 0, 1, 0,  0, 0,  9, 1, 10, 1, 0, 0, 0,  STALL,  1, 3);
        tbl[27] = mk(1, 0, 1, 0,  0, 0,  9, 1, 10, 1, 0, 0, 0,  NORM,   2, 3);
        tbl[28] = mk(1, 0, 1, 0,  0, 0,  0, 0, 10, 1, 1, 0, 0,  NORM,   2, 3);
        tbl[29] = mk(1, 1, 1, 0, 10, 1,  0, 0, 11, 1, 0, 0, 0,  FREEZE, 2, 3);
        tbl[30] = mk(1, 0, 1, 0, 10, 1,  0, 0, 11, 1, 0, 0, 0,  NORM,   0, 0);
        tbl[31] = mk(1, 0, 1, 0,  0, 0,  0, 0,  0, 1, 1, 0, 0,  NORM,   0, 0);
        tbl[32] = mk(1, 0, 1, 0,  0, 1,  0, 0, 12, 1, 0, 0, 0,  NORM,   0, 0);

        repeat (2) @(posedge clk);
        for (int i = 0; i < 33; i++) begin
            drive(tbl[i]);
        end

        // No-forwarding instance: back-to-back RAW, x0 destination, unused source, counter wrap
        rst = 1'b1;
        @(posedge clk);
        drive(mk(0, 1, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  FREEZE, 0, 0));
        drive(mk(0, 0, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  NORM,   0, 0));
        drive(mk(0, 0, 1, 0,  1, 1, 2, 1,  3, 1, 0, 0, 0,  NORM,   0, 0));
        drive(mk(0, 0, 1, 0,  3, 1, 1, 1,  4, 1, 0, 0, 0,  STALL,  0, 0));
        drive(mk(0, 0, 1, 0,  3, 1, 1, 1,  4, 1, 0, 0, 0,  STALL,  1, 0));
        drive(mk(0, 0, 1, 0,  3, 1, 1, 1,  4, 1, 0, 0, 0,  NORM,   2, 0));
        drive(mk(0, 0, 1, 0,  1, 1, 2, 1,  0, 1, 0, 0, 0,  NORM,   2, 0));
        drive(mk(0, 0, 1, 0,  0, 1, 4, 0,  7, 1, 0, 0, 0,  NORM,   2, 0));
        drive(mk(0, 0, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  NORM,   2, 0));
        drive(mk(0, 0, 1, 0,  1, 1, 2, 1,  3, 1, 0, 0, 0,  NORM,   2, 0));
        drive(mk(0, 0, 1, 0,  3, 1, 1, 1,  4, 1, 0, 0, 0,  STALL,  2, 0));
        drive(mk(0, 0, 1, 0,  3, 1, 1, 1,  4, 1, 0, 0, 0,  STALL,  3, 0));
        drive(mk(0, 0, 1, 0,  3, 1, 1, 1,  4, 1, 0, 0, 0,  NORM,   0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", napplied, nmis);
        $finish;
    end

endmodule
